// File: rtl/strobe_timer_bank.sv
// strobe_timer_bank: a bank of independent edge-triggered strobe generators.
// Each channel supports one-shot, retriggerable and periodic modes and
// reports the end of every active phase with a one-cycle DONE pulse.
module strobe_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [NUM_CH-1:0] flag_i,
  input  logic [CNT_W-1:0]  duration_i,
  input  logic [1:0]        mode_i,
  input  logic              clear_i,
  output logic [NUM_CH-1:0] strobe_control_o,
  output logic [NUM_CH-1:0] done_o,
  output logic              busy_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_RETRIG   = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Shared decode of the duration and mode inputs.
  logic       dur_nz;
  logic [1:0] mode_sel;

  assign dur_nz   = (duration_i != CNT_ZERO);
  // Mode 11 behaves as one-shot, so it is folded at latch time.
  assign mode_sel = (mode_i == 2'b11) ? MODE_ONESHOT : mode_i;

  logic [NUM_CH-1:0] ch_busy_d;
  logic              busy_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [1:0]       mode_q, mode_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic             flag_q;
    logic             trig;

    // A trigger is a rising edge of the channel flag.
    assign trig = flag_i[gi] & ~flag_q;

    // Per-channel next-state: CLEAR first, then the FSM proper.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dur_d    = dur_q;
      mode_d   = mode_q;
      strobe_d = strobe_q;
      done_d   = 1'b0;
      if (clear_i) begin
        state_d  = ST_IDLE;
        cnt_d    = CNT_ZERO;
        strobe_d = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Zero-length triggers are ignored entirely.
            if (trig && dur_nz) begin
              state_d  = ST_ACTIVE;
              strobe_d = 1'b1;
              cnt_d    = duration_i;
              dur_d    = duration_i;
              mode_d   = mode_sel;
            end
          end
          ST_ACTIVE: begin
            // A retrigger wins over the terminal count: no DONE, no gap.
            if (mode_q == MODE_RETRIG && trig && dur_nz) begin
              cnt_d = duration_i;
              dur_d = duration_i;
            end else if (cnt_q == CNT_ONE) begin
              strobe_d = 1'b0;
              done_d   = 1'b1;
              if (mode_q == MODE_PERIODIC && flag_i[gi]) begin
                state_d = ST_GAP;
                cnt_d   = dur_q;
              end else begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          ST_GAP: begin
            // Dropping the flag during the gap stops the period at once.
            if (!flag_i[gi]) begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_ONE) begin
              state_d  = ST_ACTIVE;
              strobe_d = 1'b1;
              cnt_d    = dur_q;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_d  = ST_IDLE;
            cnt_d    = CNT_ZERO;
            strobe_d = 1'b0;
          end
        endcase
      end
    end

    // Channel state registers; the flag history resets high so a level
    // held across reset release is not mistaken for an edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_q  <= ST_IDLE;
        cnt_q    <= CNT_ZERO;
        dur_q    <= CNT_ZERO;
        mode_q   <= MODE_ONESHOT;
        strobe_q <= 1'b0;
        done_q   <= 1'b0;
        flag_q   <= 1'b1;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        dur_q    <= dur_d;
        mode_q   <= mode_d;
        strobe_q <= strobe_d;
        done_q   <= done_d;
        flag_q   <= flag_i[gi];
      end
    end

    assign strobe_control_o[gi] = strobe_q;
    assign done_o[gi]           = done_q;
    assign ch_busy_d[gi]        = (state_d != ST_IDLE);
  end

  // BUSY comes from next-state so it rises together with the first strobe.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= |ch_busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_strobe_timer_bank.sv
// Testbench for strobe_timer_bank: cycle scoreboard against a reference
// model, plus scenario-level checks of pulse lengths and DONE counts.
module tb_strobe_timer_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;

  logic              clk;
  logic              reset_n;
  logic [NUM_CH-1:0] flag;
  logic [CNT_W-1:0]  duration;
  logic [1:0]        mode;
  logic              clear;
  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] done;
  logic              busy;

  strobe_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .flag_i           (flag),
    .duration_i       (duration),
    .mode_i           (mode),
    .clear_i          (clear),
    .strobe_control_o (strobe),
    .done_o           (done),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_st  [NUM_CH];
  int unsigned m_cnt [NUM_CH];
  int unsigned m_d   [NUM_CH];
  logic [1:0]  m_mode[NUM_CH];
  logic [NUM_CH-1:0] m_fq, m_strb, m_done;
  logic        m_busy;

  logic [31:0] exp_q[$];
  int hi_cnt, done_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%h t=%0t", tag, got, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_st[c] = 0; m_cnt[c] = 0; m_d[c] = 0; m_mode[c] = 2'b00;
    end
    m_fq   = '1;
    m_strb = '0;
    m_done = '0;
    m_busy = 1'b0;
    exp_q.delete();
  endtask

  // Predict the outputs after the next posedge from the current inputs.
  task automatic model_step();
    logic trig;
    for (int c = 0; c < NUM_CH; c++) begin
      trig = flag[c] & ~m_fq[c];
      m_done[c] = 1'b0;
      if (clear) begin
        m_st[c] = 0; m_cnt[c] = 0; m_strb[c] = 1'b0;
      end else if (m_st[c] == 0) begin
        if (trig && duration != 0) begin
          m_st[c] = 1; m_strb[c] = 1'b1; m_cnt[c] = duration; m_d[c] = duration;
          m_mode[c] = (mode == 2'b11) ? 2'b00 : mode;
        end
      end else if (m_st[c] == 1) begin
        if (m_mode[c] == 2'b01 && trig && duration != 0) begin
          m_cnt[c] = duration; m_d[c] = duration;
        end else if (m_cnt[c] == 1) begin
          m_strb[c] = 1'b0; m_done[c] = 1'b1;
          if (m_mode[c] == 2'b10 && flag[c]) begin
            m_st[c] = 2; m_cnt[c] = m_d[c];
          end else begin
            m_st[c] = 0; m_cnt[c] = 0;
          end
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end else begin
        if (!flag[c]) begin
          m_st[c] = 0; m_cnt[c] = 0;
        end else if (m_cnt[c] == 1) begin
          m_st[c] = 1; m_strb[c] = 1'b1; m_cnt[c] = m_d[c];
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
      m_fq[c] = flag[c];
    end
    m_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) if (m_st[c] != 0) m_busy = 1'b1;
  endtask

  // One clock: push prediction, let the DUT clock, pop and compare.
  task automatic step(input string tag);
    logic [31:0] got;
    model_step();
    exp_q.push_back({23'b0, m_strb, m_done, m_busy});
    @(posedge clk);
    #1;
    got = {23'b0, strobe, done, busy};
    check_val(tag, got, exp_q.pop_front());
    hi_cnt   += int'(strobe[0]);
    done_cnt += int'(done[0]);
  endtask

  task automatic clr_stats();
    hi_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; flag = '0; duration = '0; mode = 2'b00; clear = 1'b0;
    model_reset();
    clr_stats();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_out", {23'b0, strobe, done, busy}, 32'h0);
    reset_n = 1'b1;

    // One-shot, D=5; second edge mid-pulse ignored
    duration = 24'd5; mode = 2'b00;
    clr_stats();
    flag[0] = 1'b1; step("os");
    flag[0] = 1'b0; step("os"); step("os");
    flag[0] = 1'b1; step("os");
    for (int i = 0; i < 6; i++) step("os");
    flag[0] = 1'b0; step("os");
    check_val("os_high_len", hi_cnt, 5);
    check_val("os_done_cnt", done_cnt, 1);

    // Retriggerable, D=4, retrigger three cycles after the first edge
    duration = 24'd4; mode = 2'b01;
    clr_stats();
    flag[0] = 1'b1; step("rt");
    flag[0] = 1'b0; step("rt"); step("rt");
    flag[0] = 1'b1; step("rt");
    flag[0] = 1'b0;
    for (int i = 0; i < 8; i++) step("rt");
    check_val("rt_high_len", hi_cnt, 7);
    check_val("rt_done_cnt", done_cnt, 1);

    // Periodic, D=3, flag held 14 cycles
    duration = 24'd3; mode = 2'b10;
    clr_stats();
    flag[0] = 1'b1;
    for (int i = 0; i < 14; i++) step("per");
    flag[0] = 1'b0;
    for (int i = 0; i < 6; i++) step("per");
    check_val("per_high_len", hi_cnt, 9);
    check_val("per_done_cnt", done_cnt, 3);

    // Periodic, flag dropped during the gap
    clr_stats();
    flag[0] = 1'b1;
    for (int i = 0; i < 5; i++) step("pgap");
    flag[0] = 1'b0; step("pgap");
    check_val("pgap_busy", {31'b0, busy}, 32'h0);
    step("pgap");
    check_val("pgap_done_cnt", done_cnt, 1);

    // Zero duration trigger is ignored
    duration = '0; mode = 2'b00;
    flag[0] = 1'b1; step("dz");
    check_val("dz_busy", {31'b0, busy}, 32'h0);
    flag[0] = 1'b0; step("dz");

    // Maximum duration aborted by CLEAR
    duration = 24'hFF_FFFF;
    clr_stats();
    flag[0] = 1'b1; step("clr");
    flag[0] = 1'b0;
    for (int i = 0; i < 9; i++) step("clr");
    clear = 1'b1; step("clr");
    check_val("clr_strobe", {28'b0, strobe}, 32'h0);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) step("clr");
    check_val("clr_done_cnt", done_cnt, 0);

    // Flags held high across reset release must not trigger
    #2 reset_n = 1'b0;
    flag = 4'hF; duration = 24'd6; mode = 2'b00;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step("rrel");
    check_val("rrel_strobe", {28'b0, strobe}, 32'h0);
    flag = 4'h0; step("rrel");
    flag = 4'hF; step("all");
    check_val("all_strobe", {28'b0, strobe}, 32'hF);
    step("all"); step("all");

    // Asynchronous reset in the middle of the pulses
    #3 reset_n = 1'b0;
    #1;
    check_val("async_rst", {23'b0, strobe, done, busy}, 32'h0);
    flag = 4'h0;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Random traffic on all channels
    for (int i = 0; i < 250; i++) begin
      flag     = NUM_CH'($urandom);
      mode     = 2'($urandom_range(0, 3));
      duration = CNT_W'($urandom_range(0, 5));
      clear    = ($urandom_range(0, 24) == 0);
      step("rnd");
    end
    clear = 1'b0; flag = '0;
    for (int i = 0; i < 10; i++) step("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/strobe_timer_bank.md
STROBE_TIMER_BANK -- requirements
Module: strobe_timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent strobe channels (1..32).
REQ-002 Parameter CNT_W, default 24, width of the duration counter; max duration 2^CNT_W-1 cycles.
REQ-003 CLK  input  1  single clock; all logic on posedge.
REQ-004 RESET_N  input  1  reset; asynchronous, active-low.
REQ-005 FLAG  input  NUM_CH  per-channel trigger level; the rising edge is the trigger.
REQ-006 DURATION  input  CNT_W  shared strobe length in cycles; sampled per channel at trigger or reload.
REQ-007 MODE  input  2  shared: 00 one-shot, 01 retriggerable, 10 periodic, 11 treated as 00; latched per channel at trigger.
REQ-008 CLEAR  input  1  synchronous abort of all channels.
REQ-009 STROBE_CONTROL  output  NUM_CH  registered strobe per channel.
REQ-010 DONE  output  NUM_CH  registered 1-cycle pulse at the end of each active phase.
REQ-011 BUSY  output  1  registered OR of all channels not in IDLE.

Function
REQ-012 Each channel shall hold its own FSM (IDLE, ACTIVE, GAP), CNT_W-bit down-counter, latched duration, latched mode and FLAG history register FLAG_Q.
REQ-013 Trigger: FLAG[i]=1 and FLAG_Q[i]=0 at the same posedge. FLAG_Q[i] takes FLAG[i] every cycle.
REQ-014 IDLE + trigger with DURATION!=0: at that posedge go to ACTIVE, STROBE_CONTROL[i]<=1, CNT<=DURATION, latch DURATION and MODE.
REQ-015 IDLE + trigger with DURATION=0: ignore the trigger; stay IDLE; no strobe, no DONE.
REQ-016 ACTIVE, CNT!=1: CNT<=CNT-1. The strobe is high for exactly D cycles after the trigger edge.
REQ-017 ACTIVE, CNT==1: STROBE_CONTROL[i]<=0 and DONE[i]<=1 for one cycle.
REQ-018 At the end of ACTIVE, in periodic mode with FLAG[i]=1: go to GAP with CNT<=latched D.
REQ-019 At the end of ACTIVE in all other cases: go to IDLE.
REQ-020 One-shot mode: triggers in ACTIVE shall be ignored.
REQ-021 Retriggerable mode, trigger in ACTIVE with DURATION!=0: CNT<=DURATION and the latched D is updated; the strobe stays high.
REQ-022 Retriggerable mode, trigger in ACTIVE with DURATION=0: the trigger is ignored.
REQ-023 Retrigger at the same posedge as CNT==1: the retrigger wins; no DONE pulse, no strobe gap.
REQ-024 Periodic mode, GAP: the strobe is low. CNT decrements.
REQ-025 Periodic mode, GAP with CNT==1 and FLAG[i]=1: go to ACTIVE, strobe<=1, CNT<=latched D. The period is 2*D cycles.
REQ-026 Periodic mode, GAP with FLAG[i]=0 sampled: go to IDLE at that posedge.
REQ-027 Periodic mode, FLAG[i] falling in ACTIVE: the current pulse completes normally.
REQ-028 CLEAR=1 at a posedge overrides all other events. All channels go to IDLE and STROBE_CONTROL, DONE and CNT go to 0 next cycle. FLAG_Q still updates, so a FLAG held high through CLEAR does not retrigger.
REQ-029 Channels shall be fully independent. Simultaneous triggers on several channels are all honoured in the same cycle.
REQ-030 The counter shall never wrap: it is only loaded with a nonzero value and leaves ACTIVE or GAP at 1.
REQ-031 BUSY shall be registered from the next-state values, so it rises in the same cycle as the first strobe.

Reset
REQ-032 RESET_N=0 shall immediately drive STROBE_CONTROL=0, DONE=0, BUSY=0, CNT=0, all FSMs to IDLE, latched D/mode to 0, and FLAG_Q to all ones.
REQ-033 Because FLAG_Q resets to all ones, a FLAG held high across reset release shall not trigger; it must be seen low first.
REQ-034 Reset asserted mid-pulse shall drop the strobe without a DONE pulse.
REQ-035 Release of RESET_N shall be synchronised externally. The block takes no action until the first posedge after release.

Verification
REQ-036 One-shot, D=5, FLAG 0->1 on ch0 -> strobe high exactly 5 cycles, DONE[0] 1 cycle at the falling cycle, BUSY tracks it; a second FLAG edge mid-pulse has no effect.
REQ-037 Retriggerable, D=4, second trigger 3 cycles after the first -> strobe continuously high 7 cycles, single DONE.
REQ-038 Periodic, D=3, FLAG held high 14 cycles -> strobe pattern 3 high/3 low repeating; FLAG low during GAP -> IDLE next cycle; DONE after each high phase.
REQ-039 DURATION=0 trigger -> no strobe, BUSY stays 0. DURATION=2^24-1 trigger then CLEAR after 10 cycles -> strobe low next cycle, no DONE.
REQ-040 FLAG[3:0] held 4'hF through reset release -> no strobes. Then all low then all high -> all four channels strobe in the same cycle. RESET_N pulsed low mid-pulse -> outputs 0 asynchronously.
